// File: rtl/ahb_to_apb_bridge_if.sv
// AHB-Lite slave side and APB master side signals of the AHB-to-APB bridge.
// The slave modport is the bridge's view. The master modport is the view of the surrounding system.
interface ahb_to_apb_bridge_if #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 32
);
    logic                      hsel;
    logic [AHB_ADDR_WIDTH-1:0] haddr;
    logic [1:0]                htrans;
    logic                      hwrite;
    logic [2:0]                hsize;
    logic [DATA_WIDTH-1:0]     hwdata;
    logic                      hready;
    logic                      hreadyout;
    logic [DATA_WIDTH-1:0]     hrdata;
    logic                      hresp;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pready;
    logic                      pslverr;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hrdata, hresp,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hrdata, hresp,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to single-slave APB master bridge. All outputs are registered.
// Define APB_TIMEOUT_EN to add the ACCESS-phase watchdog, which is limited by TIMEOUT_CYCLES.
module ahb_to_apb_bridge #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                resetn,
    ahb_to_apb_bridge_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_e;

    state_e                    state_q, state_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0]     hrdata_q, hrdata_d;
    logic                      hreadyout_q, hreadyout_d;
    logic                      hresp_q, hresp_d;
    logic                      capture;
`ifdef APB_TIMEOUT_EN
    logic [15:0]               cnt_q, cnt_d;
`endif

    assign capture = bus.hsel && bus.hready && bus.htrans[1] && hreadyout_q;

    // The upper address bits and htrans[0] are not used by this bridge.
    logic unused_bits;
    assign unused_bits = ^{bus.haddr[AHB_ADDR_WIDTH-1:APB_ADDR_WIDTH], bus.htrans[0], TIMEOUT_CYCLES[0]};

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hrdata_d    = hrdata_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
`ifdef APB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: if (capture) begin
                paddr_d     = bus.haddr[APB_ADDR_WIDTH-1:0];
                pwrite_d    = bus.hwrite;
                hreadyout_d = 1'b0;
                if (bus.hsize != 3'b010) begin
                    state_d = ERR1;
                    hresp_d = 1'b1;
                end else if (bus.hwrite) begin
                    state_d = WDATA;
                end else begin
                    state_d = SETUP;
                    psel_d  = 1'b1;
                end
            end
            WDATA: begin
                pwdata_d = bus.hwdata;
                psel_d   = 1'b1;
                state_d  = SETUP;
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: if (bus.pready) begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (bus.pslverr) begin
                    state_d = ERR1;
                    hresp_d = 1'b1;
                end else begin
                    if (!pwrite_q) hrdata_d = bus.prdata;
                    hreadyout_d = 1'b1;
                    state_d     = IDLE;
                end
            end
`ifdef APB_TIMEOUT_EN
            // A late pready in the final allowed cycle wins over the watchdog.
            else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                hresp_d   = 1'b1;
                state_d   = ERR1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
`endif
            ERR1: begin
                hreadyout_d = 1'b1;
                state_d     = ERR2;
            end
            ERR2: begin
                hresp_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.hrdata    = hrdata_q;
    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
endmodule
